rv64g_regfile_sb: RTL and testbench

Scoreboarded, multi-port integer register file for the rv64g core. It replaces the single-lock scheme with a per-register pending-write counter, so several in-flight writes to one destination are tracked. It provides NRP read ports with same-cycle writeback bypass, NWP writeback ports, a lock-request valid/ready handshake, a flush, and a sticky underflow error. It sits between decode/issue, which locks destinations and reads sources, and the execution-unit writeback buses.

---
 rtl/rv64g_regfile_sb.sv | 107 ++++++++++
 tb/tb_rv64g_regfile_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rv64g_regfile_sb.sv
// rv64g_regfile_sb: multi-port integer register file with per-register pending-write counters
module rv64g_regfile_sb #(
   parameter int NR = 32,
   parameter int DW = 64,
   parameter int NRP = 3,
   parameter int NWP = 2,
   parameter int CW = 2,
   parameter int ZERO_REG = 1,
   localparam int AW = $clog2(NR)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              lock_valid_i,
   input  logic [AW-1:0]     lock_addr_i,
   output logic              lock_ready_o,
   input  logic [NWP-1:0]    wb_valid_i,
   input  logic [NWP*AW-1:0] wb_addr_i,
   input  logic [NWP*DW-1:0] wb_data_i,
   input  logic              flush_i,
   input  logic [NRP*AW-1:0] rd_addr_i,
   output logic [NRP*DW-1:0] rd_data_o,
   output logic [NRP-1:0]    rd_busy_o,
   output logic [NR-1:0]     locks_o,
   output logic              err_o
);
   localparam int SW = CW + $clog2(NWP + 1) + 1;
   localparam logic [CW-1:0] MAX = '1;

   logic [DW-1:0] regs [NR];
   logic [CW-1:0] count [NR];
   logic [CW-1:0] count_nx [NR];
   logic [SW-1:0] dec [NR];
   logic [SW-1:0] sum [NR];
   logic [AW-1:0] ra [NRP];
   logic          lock_acc, uflow, err_q;

   assign lock_ready_o = rst_ni & ~flush_i & (count[lock_addr_i] != MAX);
   assign lock_acc = lock_valid_i & lock_ready_o;
   assign err_o = err_q;

   // Number of valid writeback ports hitting each register; the zero register is never counted
   always_comb begin
      for (int r = 0; r < NR; r++) begin
         dec[r] = '0;
         for (int p = 0; p < NWP; p++)
            dec[r] = dec[r] + SW'(wb_valid_i[p] && wb_addr_i[p*AW +: AW] == AW'(r) && !(ZERO_REG != 0 && r == 0));
      end
   end

   // Next pending count as a signed sum clamped to 0..MAX; flush and the zero register force 0
   always_comb begin
      uflow = 1'b0;
      for (int r = 0; r < NR; r++) begin
         sum[r] = SW'(count[r]) + SW'(lock_acc && lock_addr_i == AW'(r)) - dec[r];
         count_nx[r] = (flush_i || (ZERO_REG != 0 && r == 0) || sum[r][SW-1]) ? '0 :
                       (sum[r] > SW'(MAX)) ? MAX : sum[r][CW-1:0];
         uflow = uflow | (dec[r] > SW'(count[r]));
      end
   end

   // Registered lock view
   always_comb begin
      for (int r = 0; r < NR; r++)
         locks_o[r] = count[r] != '0;
   end

   // Read ports: highest-index matching writeback bypasses the stored value
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int k = 0; k < NRP; k++) begin
         ra[k] = rd_addr_i[k*AW +: AW];
         rd_data_o[k*DW +: DW] = regs[ra[k]];
         for (int p = 0; p < NWP; p++)
            if (wb_valid_i[p] && wb_addr_i[p*AW +: AW] == ra[k])
               rd_data_o[k*DW +: DW] = wb_data_i[p*DW +: DW];
         if (ZERO_REG != 0 && ra[k] == '0)
            rd_data_o[k*DW +: DW] = '0;
         rd_busy_o[k] = !flush_i && (SW'(count[ra[k]]) > dec[ra[k]]);
      end
   end

   // Pending counters and sticky underflow flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
         for (int r = 0; r < NR; r++)
            count[r] <= '0;
      end else begin
         err_q <= err_q | (uflow & ~flush_i);
         for (int r = 0; r < NR; r++)
            count[r] <= count_nx[r];
      end
   end

   // Register data; later ports override earlier ones on a shared address
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int r = 0; r < NR; r++)
            regs[r] <= '0;
      end else begin
         for (int p = 0; p < NWP; p++)
            if (wb_valid_i[p] && !(ZERO_REG != 0 && wb_addr_i[p*AW +: AW] == '0))
               regs[wb_addr_i[p*AW +: AW]] <= wb_data_i[p*DW +: DW];
      end
   end
endmodule

// File: tb/tb_rv64g_regfile_sb.sv
// tb_rv64g_regfile_sb: randomized scoreboard bench with a behavioural register-file model
module tb_rv64g_regfile_sb;
   typedef struct packed {
      logic [191:0] d;
      logic [2:0]   busy;
      logic [31:0]  locks;
      logic         err;
      logic         rdy;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0, lock_valid_i = 1'b0, flush_i = 1'b0;
   logic [4:0]   lock_addr_i = '0;
   logic [1:0]   wb_valid_i = '0;
   logic [9:0]   wb_addr_i = '0;
   logic [127:0] wb_data_i = '0;
   logic [14:0]  rd_addr_i = '0;
   logic [191:0] rd_data_o;
   logic [2:0]   rd_busy_o;
   logic [31:0]  locks_o;
   logic         lock_ready_o, err_o;

   rv64g_regfile_sb dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .lock_valid_i(lock_valid_i), .lock_addr_i(lock_addr_i),
      .lock_ready_o(lock_ready_o), .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
      .wb_data_i(wb_data_i), .flush_i(flush_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .rd_busy_o(rd_busy_o), .locks_o(locks_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int          tests = 0, failed = 0;
   exp_t        q[$];
   int          m_cnt [32];
   logic [63:0] m_regs [32];
   logic        m_err;

   logic        n_rst, n_lv, n_fl;
   int          n_la, n_wa0, n_wa1, n_ra0, n_ra1, n_ra2;
   logic [1:0]  n_wv;
   logic [63:0] n_wd0, n_wd1;

   function automatic int wb_a(int p);
      return int'(wb_addr_i[p*5 +: 5]);
   endfunction

   function automatic int hits(int r);
      int n = 0;
      for (int p = 0; p < 2; p++)
         if (wb_valid_i[p] && wb_a(p) == r && r != 0) n++;
      return n;
   endfunction

   // Apply the inputs the DUT sampled at the last edge to the model
   function automatic void commit();
      int acc, n;
      if (!rst_ni) begin
         for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_regs[r] = '0; end
         m_err = 1'b0;
         return;
      end
      acc = (lock_valid_i && !flush_i && m_cnt[lock_addr_i] != 3) ? int'(lock_addr_i) : -1;
      for (int r = 1; r < 32; r++) begin
         n = m_cnt[r] + (acc == r ? 1 : 0) - hits(r);
         if (!flush_i && hits(r) > m_cnt[r]) m_err = 1'b1;
         m_cnt[r] = flush_i ? 0 : n < 0 ? 0 : n > 3 ? 3 : n;
      end
      for (int p = 0; p < 2; p++)
         if (wb_valid_i[p] && wb_a(p) != 0) m_regs[wb_a(p)] = wb_data_i[p*64 +: 64];
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      int a;
      e.rdy = rst_ni && !flush_i && m_cnt[lock_addr_i] != 3;
      e.err = m_err;
      for (int r = 0; r < 32; r++) e.locks[r] = m_cnt[r] != 0;
      for (int k = 0; k < 3; k++) begin
         a = int'(rd_addr_i[k*5 +: 5]);
         e.d[k*64 +: 64] = m_regs[a];
         for (int p = 0; p < 2; p++)
            if (wb_valid_i[p] && wb_a(p) == a) e.d[k*64 +: 64] = wb_data_i[p*64 +: 64];
         if (a == 0) e.d[k*64 +: 64] = '0;
         e.busy[k] = !flush_i && a != 0 && (m_cnt[a] - hits(a)) > 0;
      end
      return e;
   endfunction

   task automatic clr();
      n_rst = 1'b1; n_lv = 1'b0; n_fl = 1'b0; n_la = 0; n_wv = '0;
      n_wa0 = 0; n_wa1 = 0; n_wd0 = '0; n_wd1 = '0; n_ra0 = 0; n_ra1 = 0; n_ra2 = 0;
   endtask

   task automatic rd(input int a);
      n_ra0 = a; n_ra1 = a; n_ra2 = a;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      commit();
      rst_ni = n_rst; lock_valid_i = n_lv; lock_addr_i = 5'(n_la); flush_i = n_fl;
      wb_valid_i = n_wv; wb_addr_i = {5'(n_wa1), 5'(n_wa0)}; wb_data_i = {n_wd1, n_wd0};
      rd_addr_i = {5'(n_ra2), 5'(n_ra1), 5'(n_ra0)};
      q.push_back(expect_now());
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every presented cycle pops one expectation and compares all outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < 3; k++) chk($sformatf("rd_data%0d", k), rd_data_o[k*64 +: 64], e.d[k*64 +: 64]);
            chk("rd_busy", 64'(rd_busy_o), 64'(e.busy));
            chk("locks", 64'(locks_o), 64'(e.locks));
            chk("err", 64'(err_o), 64'(e.err));
            chk("lock_ready", 64'(lock_ready_o), 64'(e.rdy));
         end
      end
   end

   initial begin
      clr(); n_rst = 1'b0; tick(); tick();
      clr(); rd(5); tick();
      clr(); n_lv = 1'b1; n_la = 3; rd(3);
      repeat (4) tick();
      clr(); rd(3); n_wv = 2'b01; n_wa0 = 3; n_wd0 = 64'hA; tick();
      n_wd0 = 64'hB; tick();
      n_wd0 = 64'hC; tick();
      clr(); rd(3); tick();
      clr(); n_lv = 1'b1; n_la = 7; tick();
      clr(); rd(7); n_wv = 2'b11; n_wa0 = 7; n_wa1 = 7; n_wd0 = 64'h11; n_wd1 = 64'h22; tick();
      clr(); rd(7); tick();
      clr(); rd(9); n_wv = 2'b01; n_wa0 = 9; n_wd0 = 64'h55; tick();
      clr(); rd(9); tick(); tick();
      clr(); n_lv = 1'b1; n_la = 4; tick();
      clr(); rd(4); n_lv = 1'b1; n_la = 4; n_wv = 2'b01; n_wa0 = 4; n_wd0 = 64'h99; tick();
      clr(); rd(4); tick();
      clr(); n_lv = 1'b1; n_la = 1; tick();
      n_la = 2; tick();
      clr(); n_lv = 1'b1; n_la = 5; n_fl = 1'b1; n_ra0 = 1; n_ra1 = 2; n_ra2 = 5; tick();
      clr(); n_wv = 2'b01; n_wa0 = 0; n_wd0 = 64'hFF; n_ra1 = 1; n_ra2 = 2; tick();
      clr(); rd(0); tick();
      clr(); n_rst = 1'b0; tick();
      for (int i = 0; i < 3000; i++) begin
         clr();
         n_rst = $urandom_range(0, 299) != 0;
         n_fl = $urandom_range(0, 39) == 0;
         n_lv = $urandom_range(0, 1) != 0;
         n_la = $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7);
         n_wv = 2'($urandom_range(0, 3));
         n_wa0 = $urandom_range(0, 7); n_wa1 = $urandom_range(0, 7);
         n_wd0 = {$urandom, $urandom}; n_wd1 = {$urandom, $urandom};
         n_ra0 = $urandom_range(0, 7); n_ra1 = $urandom_range(0, 7); n_ra2 = $urandom_range(0, 31);
         if ($urandom_range(0, 9) < 4) n_wv = '0;
         tick();
      end
      @(negedge clk_i);
      #1;
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
